// File: rtl/ram_writer.sv
// Command-driven RAM access engine: single-word WRITE, multi-word FILL, READ
// with configurable RAM read latency, and NOP; all outputs are registered.
module ram_writer #(
    parameter int WIDTH             = 16,
    parameter int REGISTER_COUNT    = 256,
    parameter int RAM_SCREEN_OFFSET = 0,
    parameter int READ_LATENCY      = 1,
    localparam int AW               = $clog2(REGISTER_COUNT)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [AW-1:0]    cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [AW-1:0]    ram_addr,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             done,
    output logic             busy
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITE     = 2'd1;
    localparam logic [1:0] S_FILL      = 2'd2;
    localparam logic [1:0] S_READ_WAIT = 2'd3;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    // AW-bit wrap makes the offset addition modulo REGISTER_COUNT (power of two depth)
    localparam logic [AW-1:0] OFF = AW'(RAM_SCREEN_OFFSET % REGISTER_COUNT);
    localparam logic [2:0]    LAT = 3'(READ_LATENCY);

    logic [1:0]    state_r;
    logic [AW-1:0] cnt_r;
    logic [2:0]    wait_r;
    logic [AW-1:0] base_s;

    assign base_s = cmd_addr + OFF;

    // Command FSM; every output is a flop updated here
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r   <= S_IDLE;
            cnt_r     <= '0;
            wait_r    <= 3'd0;
            cmd_ready <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    rsp_valid <= 1'b0;
                    ram_we    <= 1'b0;
                    if (!cmd_ready) begin
                        // first cycle after reset, or the done cycle of a NOP
                        cmd_ready <= 1'b1;
                        done      <= 1'b0;
                    end else if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        case (cmd_op)
                            OP_WRITE: begin
                                ram_we    <= 1'b1;
                                ram_addr  <= base_s;
                                ram_wdata <= cmd_data;
                                done      <= 1'b1;
                                busy      <= 1'b1;
                                state_r   <= S_WRITE;
                            end
                            OP_FILL: begin
                                ram_we    <= 1'b1;
                                ram_addr  <= base_s;
                                ram_wdata <= cmd_data;
                                cnt_r     <= cmd_len;
                                done      <= (cmd_len == '0);
                                busy      <= 1'b1;
                                state_r   <= S_FILL;
                            end
                            OP_READ: begin
                                ram_addr  <= base_s;
                                wait_r    <= 3'd0;
                                done      <= 1'b0;
                                busy      <= 1'b1;
                                state_r   <= S_READ_WAIT;
                            end
                            default: begin
                                done      <= 1'b1;
                            end
                        endcase
                    end else begin
                        done <= 1'b0;
                    end
                end
                S_WRITE: begin
                    ram_we    <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= S_IDLE;
                end
                S_FILL: begin
                    if (cnt_r == '0) begin
                        ram_we    <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        ram_addr <= ram_addr + AW'(1);
                        cnt_r    <= cnt_r - AW'(1);
                        done     <= (cnt_r == AW'(1));
                    end
                end
                S_READ_WAIT: begin
                    // ram_addr is held, so the RAM output is stable once LAT cycles pass
                    if (wait_r == LAT) begin
                        rsp_data  <= ram_rdata;
                        rsp_valid <= 1'b1;
                        done      <= 1'b1;
                        wait_r    <= wait_r + 3'd1;
                    end else if (wait_r > LAT) begin
                        rsp_valid <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        wait_r <= wait_r + 3'd1;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    cmd_ready <= 1'b0;
                    ram_we    <= 1'b0;
                    rsp_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_writer.sv
// Scoreboard bench for ram_writer: three instances (latency 1, latency 3,
// offset 0xF0) share one command stream; each has its own RAM model.
module tb_ram_writer;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        last;
    } wr_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        preload = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b11;
    logic [7:0]  cmd_addr = 8'h00;
    logic [7:0]  cmd_len = 8'h00;
    logic [15:0] cmd_data = 16'h0000;

    logic        r1_ready, r1_we, r1_rsp_valid, r1_done, r1_busy;
    logic [7:0]  r1_addr;
    logic [15:0] r1_wdata, r1_rdata, r1_rsp_data;
    logic        r3_ready, r3_we, r3_rsp_valid, r3_done, r3_busy;
    logic [7:0]  r3_addr;
    logic [15:0] r3_wdata, r3_rdata, r3_rsp_data;
    logic        ro_ready, ro_we, ro_rsp_valid, ro_done, ro_busy;
    logic [7:0]  ro_addr;
    logic [15:0] ro_wdata, ro_rdata, ro_rsp_data;

    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];
    logic [15:0] memo [256];
    logic [15:0] p3a, p3b, p3c;

    wr_t         wq1[$];
    wr_t         wqo[$];
    logic [15:0] rq1[$];
    logic [15:0] rq3[$];

    int n_cmp = 0;
    int n_err = 0;
    int exp_done = 0;
    int act_done = 0;
    logic done_d = 1'b0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    ram_writer #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .resetN(resetN), .cmd_valid(cmd_valid), .cmd_ready(r1_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .ram_addr(r1_addr), .ram_we(r1_we), .ram_wdata(r1_wdata), .ram_rdata(r1_rdata),
        .rsp_valid(r1_rsp_valid), .rsp_data(r1_rsp_data), .done(r1_done), .busy(r1_busy));

    ram_writer #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .resetN(resetN), .cmd_valid(cmd_valid), .cmd_ready(r3_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .ram_addr(r3_addr), .ram_we(r3_we), .ram_wdata(r3_wdata), .ram_rdata(r3_rdata),
        .rsp_valid(r3_rsp_valid), .rsp_data(r3_rsp_data), .done(r3_done), .busy(r3_busy));

    ram_writer #(.RAM_SCREEN_OFFSET(8'hF0)) duto (
        .clk(clk), .resetN(resetN), .cmd_valid(cmd_valid), .cmd_ready(ro_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .ram_addr(ro_addr), .ram_we(ro_we), .ram_wdata(ro_wdata), .ram_rdata(ro_rdata),
        .rsp_valid(ro_rsp_valid), .rsp_data(ro_rsp_data), .done(ro_done), .busy(ro_busy));

    // RAM models: latency-1 and latency-3 synchronous read ports
    always @(posedge clk) begin
        if (preload) begin
            mem1[8'h20] <= 16'hA5A5;
            mem3[8'h20] <= 16'hA5A5;
        end
        if (r1_we) mem1[r1_addr] <= r1_wdata;
        if (r3_we) mem3[r3_addr] <= r3_wdata;
        if (ro_we) memo[ro_addr] <= ro_wdata;
        r1_rdata <= mem1[r1_addr];
        ro_rdata <= memo[ro_addr];
        p3a <= mem3[r3_addr];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign r3_rdata = p3c;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops scoreboard entries as the DUTs produce writes/responses
    always @(negedge clk) begin
        if (mon_en) begin
            if (r1_we) begin
                if (wq1.size() == 0) check("w1_unexpected", 32'(r1_addr), 32'hFFFF_FFFF);
                else begin
                    wr_t e;
                    e = wq1.pop_front();
                    check("w1_addr", 32'(r1_addr), 32'(e.addr));
                    check("w1_data", 32'(r1_wdata), 32'(e.data));
                    check("w1_done", 32'(r1_done), 32'(e.last));
                    check("w1_busy", 32'(r1_busy), 32'd1);
                end
            end
            if (ro_we) begin
                if (wqo.size() == 0) check("wo_unexpected", 32'(ro_addr), 32'hFFFF_FFFF);
                else begin
                    wr_t e;
                    e = wqo.pop_front();
                    check("wo_addr", 32'(ro_addr), 32'(e.addr));
                    check("wo_data", 32'(ro_wdata), 32'(e.data));
                end
            end
            if (r1_rsp_valid) begin
                if (rq1.size() == 0) check("rsp1_unexpected", 32'(r1_rsp_data), 32'hFFFF_FFFF);
                else begin
                    check("rsp1_data", 32'(r1_rsp_data), 32'(rq1.pop_front()));
                    check("rsp1_done", 32'(r1_done), 32'd1);
                end
            end
            if (r3_rsp_valid) begin
                if (rq3.size() == 0) check("rsp3_unexpected", 32'(r3_rsp_data), 32'hFFFF_FFFF);
                else begin
                    check("rsp3_data", 32'(r3_rsp_data), 32'(rq3.pop_front()));
                    check("rsp3_done", 32'(r3_done), 32'd1);
                end
            end
            if (r1_done) act_done <= act_done + 1;
            if (done_d && resetN) check("ready_after_done", 32'(r1_ready), 32'd1);
            done_d <= r1_done;
        end
    end

    task automatic push_write(input logic [7:0] a, input logic [15:0] d, input logic last);
        logic [7:0] ao;
        ao = a + 8'hF0;
        wq1.push_back('{addr: a, data: d, last: last});
        wqo.push_back('{addr: ao, data: d, last: last});
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 300; i++) begin
            if (r1_ready && r3_ready && ro_ready) break;
            @(negedge clk);
        end
        if (i == 300) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic scramble();
        cmd_op   = 2'($urandom);
        cmd_addr = 8'($urandom);
        cmd_len  = 8'($urandom);
        cmd_data = 16'($urandom);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] len,
                         input logic [15:0] data, input logic [15:0] rexp);
        logic [7:0] a;
        wait_ready();
        cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        case (op)
            2'b00: push_write(addr, data, 1'b1);
            2'b01: for (int i = 0; i <= int'(len); i++) begin
                a = addr + 8'(i);
                push_write(a, data, i == int'(len));
            end
            2'b10: begin rq1.push_back(rexp); rq3.push_back(rexp); end
            default: ;
        endcase
        exp_done++;
        @(negedge clk);
        cmd_valid = 1'b0;
        scramble();
    endtask

    initial begin
        logic found;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(r1_ready), 32'd0);
        check("rst_we", 32'(r1_we), 32'd0);
        check("rst_done", 32'(r1_done), 32'd0);
        check("rst_busy", 32'(r1_busy), 32'd0);
        check("rst_rsp_valid", 32'(r1_rsp_valid), 32'd0);
        check("rst_addr", 32'(r1_addr), 32'd0);
        preload = 1'b0;
        mon_en = 1'b1;
        resetN = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(r1_ready), 32'd1);

        issue(2'b00, 8'h10, 8'h00, 16'hBEEF, 16'h0);   // WRITE
        issue(2'b01, 8'hFE, 8'h03, 16'h1234, 16'h0);   // FILL wrapping
        issue(2'b01, 8'h33, 8'h00, 16'h0F0F, 16'h0);   // FILL single word
        issue(2'b11, 8'h44, 8'h00, 16'hDEAD, 16'h0);   // NOP
        issue(2'b10, 8'h20, 8'h00, 16'h0, 16'hA5A5);   // READ preloaded word
        issue(2'b00, 8'h20, 8'h00, 16'h1357, 16'h0);   // offset instance lands at 0x10
        issue(2'b10, 8'h20, 8'h00, 16'h0, 16'h1357);
        issue(2'b01, 8'h05, 8'hFF, 16'hC3C3, 16'h0);   // FILL whole RAM

        // fields churn with cmd_valid high during a FILL; only IDLE may accept
        wait_ready();
        cmd_op = 2'b01; cmd_addr = 8'h80; cmd_len = 8'h05; cmd_data = 16'h7777; cmd_valid = 1'b1;
        for (int i = 0; i <= 5; i++) push_write(8'h80 + 8'(i), 16'h7777, i == 5);
        push_write(8'h90, 16'h9999, 1'b1);
        exp_done += 2;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (r1_done) begin
                cmd_op = 2'b00; cmd_addr = 8'h90; cmd_data = 16'h9999;
                found = 1'b1;
                break;
            end
            scramble();
        end
        check("fill_done_seen", 32'(found), 32'd1);
        @(negedge clk);
        check("held_valid_ready", 32'(r1_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        scramble();

        // reset during the 3rd write of a 10-word FILL
        wait_ready();
        cmd_op = 2'b01; cmd_addr = 8'h40; cmd_len = 8'h09; cmd_data = 16'h5555; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) push_write(8'h40 + 8'(i), 16'h5555, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_3rd_we", 32'(r1_we), 32'd1);
        resetN = 1'b0;
        @(negedge clk);
        check("abort_we", 32'(r1_we), 32'd0);
        check("abort_done", 32'(r1_done), 32'd0);
        check("abort_busy", 32'(r1_busy), 32'd0);
        check("abort_ready", 32'(r1_ready), 32'd0);
        check("abort_addr", 32'(r1_addr), 32'd0);
        check("abort_wdata", 32'(r1_wdata), 32'd0);
        check("abort_rsp_data", 32'(r1_rsp_data), 32'd0);
        check("abort_rsp_valid", 32'(r1_rsp_valid), 32'd0);
        check("abort_wq_drained", 32'(wq1.size()), 32'd0);
        resetN = 1'b1;
        @(negedge clk);
        check("abort_ready_back", 32'(r1_ready), 32'd1);
        issue(2'b00, 8'h60, 8'h00, 16'hABCD, 16'h0);

        repeat (10) @(negedge clk);
        check("wq1_empty", 32'(wq1.size()), 32'd0);
        check("wqo_empty", 32'(wqo.size()), 32'd0);
        check("rq1_empty", 32'(rq1.size()), 32'd0);
        check("rq3_empty", 32'(rq3.size()), 32'd0);
        check("done_count", 32'(act_done), 32'(exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
